viterbi_frame_ctrl: RTL and testbench

Frame sequencer for the hard-decision Viterbi decoder (`decoder_sys`). It accepts 2-bit encoded symbols from upstream over a valid/ready handshake and latches the constraint length per frame. It clears the decoder, issues one decoder clock-enable per symbol, and then inserts `TB_DEPTH-1` padding symbols so the traceback window drains. It re-times the decoder's serial output into a framed bit stream with exactly one output bit per accepted input symbol.

---
 rtl/viterbi_pkg.sv | 23 ++
 rtl/viterbi_frame_ctrl_if.sv | 36 +++
 rtl/viterbi_out_align.sv | 42 ++++
 rtl/viterbi_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi frame sequencer.
package viterbi_pkg;

    localparam int unsigned SYM_W        = 2;
    localparam int unsigned K_W          = 3;
    localparam int unsigned K_MIN        = 3;
    localparam int unsigned K_MAX        = 6;
    localparam int unsigned TB_DEPTH_DEF = 15;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    function automatic logic k_legal(input logic [K_W-1:0] k);
        return (k >= K_W'(K_MIN)) && (k <= K_W'(K_MAX));
    endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol-in, decoder and bit-out signals of the frame sequencer.
// master is the sequencer side, slave is the upstream/decoder/sink side.
interface viterbi_frame_ctrl_if;
    import viterbi_pkg::*;

    logic [K_W-1:0] cfg_k;
    logic           start;
    logic           in_valid;
    logic           in_ready;
    sym_t           in_sym;
    logic           in_last;
    logic           dec_clr;
    logic [K_W-1:0] dec_k;
    logic           dec_en;
    sym_t           dec_sym;
    logic           dec_bit;
    logic           out_valid;
    logic           out_bit;
    logic           out_last;
    logic           busy;
    logic           err_cfg;
    logic           err_len;

    modport master (
        input  cfg_k, start, in_valid, in_sym, in_last, dec_bit,
        output in_ready, dec_clr, dec_k, dec_en, dec_sym,
               out_valid, out_bit, out_last, busy, err_cfg, err_len
    );

    modport slave (
        output cfg_k, start, in_valid, in_sym, in_last, dec_bit,
        input  in_ready, dec_clr, dec_k, dec_en, dec_sym,
               out_valid, out_bit, out_last, busy, err_cfg, err_len
    );

endinterface

// File: rtl/viterbi_out_align.sv
// Two-stage delay from a decoder issue to the framed output bit; issues that
// fall inside the traceback warm-up or past the frame length are dropped.
module viterbi_out_align (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic keep_i,
    input  logic last_i,
    input  logic dec_bit_i,
    output logic out_valid_o,
    output logic out_bit_o,
    output logic out_last_o
);

    logic v1_q;
    logic l1_q;
    logic ov_q;
    logic ob_q;
    logic ol_q;

    // Stage 1 tracks the issue while the decoder computes; stage 2 captures dec_bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            l1_q <= 1'b0;
            ov_q <= 1'b0;
            ob_q <= 1'b0;
            ol_q <= 1'b0;
        end else begin
            v1_q <= en_i & keep_i;
            l1_q <= en_i & keep_i & last_i;
            ov_q <= v1_q;
            ob_q <= v1_q & dec_bit_i;
            ol_q <= l1_q;
        end
    end

    assign out_valid_o = ov_q;
    assign out_bit_o   = ob_q;
    assign out_last_o  = ol_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the hard-decision Viterbi decoder: clears it, feeds one
// issue per symbol, pads the traceback window and frames the decoded bits.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_DEPTH  = TB_DEPTH_DEF,
    parameter int unsigned MAX_FRAME = 1023,
    parameter int unsigned CNT_W     = 10
) (
    input logic                 clk,
    input logic                 rst,
    viterbi_frame_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] PAD_N    = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FRAME - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0] n_in_q, n_in_d;
    logic [CNT_W-1:0] n_out_q, n_out_d;
    logic [CNT_W-1:0] n_qual_q, n_qual_d;
    logic [CNT_W-1:0] pad_cnt_q, pad_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             dec_clr_q, dec_clr_d;
    logic [K_W-1:0]   dec_k_q, dec_k_d;
    logic             dec_en_q, dec_en_d;
    sym_t             dec_sym_q, dec_sym_d;
    logic             keep_q, keep_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             err_cfg_q, err_cfg_d;
    logic             err_len_q, err_len_d;
    logic             hs;
    logic             issue;
    logic             out_valid;
    logic             out_bit;
    logic             out_last;

    assign hs = bus.in_valid & in_ready_q;

    always_comb begin
        state_d   = state_q;
        iss_cnt_d = iss_cnt_q;
        n_in_d    = n_in_q;
        n_out_d   = n_out_q + CNT_W'(out_valid);
        n_qual_d  = n_qual_q;
        pad_cnt_d = pad_cnt_q;
        dec_k_d   = dec_k_q;
        dec_en_d  = 1'b0;
        dec_sym_d = '0;
        keep_d    = 1'b0;
        last_d    = 1'b0;
        err_cfg_d = 1'b0;
        err_len_d = err_len_q;
        issue     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (k_legal(bus.cfg_k)) begin
                        dec_k_d   = bus.cfg_k;
                        err_len_d = 1'b0;
                        state_d   = LOAD;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                iss_cnt_d = '0;
                n_in_d    = '0;
                n_out_d   = '0;
                n_qual_d  = '0;
                pad_cnt_d = '0;
                state_d   = RUN;
            end
            RUN: begin
                if (hs) begin
                    issue     = 1'b1;
                    dec_sym_d = bus.in_sym;
                    n_in_d    = n_in_q + ONE;
                    // A full frame without in_last is closed here and flagged.
                    if (bus.in_last || (n_in_q == LAST_IDX)) begin
                        state_d = FLUSH;
                        if (!bus.in_last) begin
                            err_len_d = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (pad_cnt_q < PAD_N) begin
                    issue     = 1'b1;
                    pad_cnt_d = pad_cnt_q + ONE;
                end else if (n_out_d == n_in_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // iss_cnt saturates once the traceback window is primed, so it never wraps.
        if (issue) begin
            dec_en_d = 1'b1;
            if (iss_cnt_q >= PAD_N) begin
                if (n_qual_q < n_in_d) begin
                    keep_d   = 1'b1;
                    last_d   = (n_qual_q + ONE) == n_in_d;
                    n_qual_d = n_qual_q + ONE;
                end
            end else begin
                iss_cnt_d = iss_cnt_q + ONE;
            end
        end

        dec_clr_d  = (state_d == LOAD);
        in_ready_d = (state_d == RUN);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            iss_cnt_q  <= '0;
            n_in_q     <= '0;
            n_out_q    <= '0;
            n_qual_q   <= '0;
            pad_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            dec_clr_q  <= 1'b0;
            dec_k_q    <= K_W'(K_MIN);
            dec_en_q   <= 1'b0;
            dec_sym_q  <= '0;
            keep_q     <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_cfg_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            iss_cnt_q  <= iss_cnt_d;
            n_in_q     <= n_in_d;
            n_out_q    <= n_out_d;
            n_qual_q   <= n_qual_d;
            pad_cnt_q  <= pad_cnt_d;
            in_ready_q <= in_ready_d;
            dec_clr_q  <= dec_clr_d;
            dec_k_q    <= dec_k_d;
            dec_en_q   <= dec_en_d;
            dec_sym_q  <= dec_sym_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            err_cfg_q  <= err_cfg_d;
            err_len_q  <= err_len_d;
        end
    end

    viterbi_out_align u_align (
        .clk         (clk),
        .rst         (rst),
        .en_i        (dec_en_q),
        .keep_i      (keep_q),
        .last_i      (last_q),
        .dec_bit_i   (bus.dec_bit),
        .out_valid_o (out_valid),
        .out_bit_o   (out_bit),
        .out_last_o  (out_last)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.dec_clr   = dec_clr_q;
    assign bus.dec_k     = dec_k_q;
    assign bus.dec_en    = dec_en_q;
    assign bus.dec_sym   = dec_sym_q;
    assign bus.out_valid = out_valid;
    assign bus.out_bit   = out_bit;
    assign bus.out_last  = out_last;
    assign bus.busy      = busy_q;
    assign bus.err_cfg   = err_cfg_q;
    assign bus.err_len   = err_len_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Randomized bench for viterbi_frame_ctrl with a stand-in decoder that returns
// a known function of symbol j once symbol j+TB_DEPTH-1 has been issued.
module tb_viterbi_frame_ctrl;

    localparam int TB_DEPTH  = 15;
    localparam int MAX_FRAME = 1023;
    localparam int CNT_W     = 10;

    logic clk;
    logic rst;

    viterbi_frame_ctrl_if bus ();

    viterbi_frame_ctrl #(
        .TB_DEPTH  (TB_DEPTH),
        .MAX_FRAME (MAX_FRAME),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  frame_sym [0:1023];
    int          frame_n  = 0;
    int          mon_iss  = 0;
    int          out_cnt  = 0;
    bit          hs_prev  = 1'b0;
    bit          prev_last = 1'b0;
    logic [1:0]  exp_s;
    logic [1:0]  hist [0:2047];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // The decoded bit the stand-in decoder returns for a symbol.
    function automatic logic fbit(input logic [1:0] s);
        return s[0] ^ s[1];
    endfunction

    // Stand-in decoder: bit for issue i appears the cycle after that issue.
    initial begin : decoder_model
        int  di;
        bit  en;
        logic [1:0] s;
        bit  clr;
        di = 0;
        bus.dec_bit = 1'b0;
        forever begin
            @(negedge clk);
            en  = bus.dec_en;
            s   = bus.dec_sym;
            clr = bus.dec_clr;
            @(posedge clk);
            #1;
            if (clr) di = 0;
            if (en && !rst) begin
                hist[di] = s;
                if (di >= TB_DEPTH - 1) bus.dec_bit = fbit(hist[di - (TB_DEPTH - 1)]);
                else                    bus.dec_bit = 1'($urandom);
                di++;
            end else begin
                bus.dec_bit = 1'($urandom);
            end
        end
    end

    // Issue order, issue timing and output stream against the stimulus frame.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                hs_prev   = 1'b0;
                prev_last = 1'b0;
            end else begin
                if (bus.dec_clr) begin
                    mon_iss = 0;
                    out_cnt = 0;
                end
                if (hs_prev || (bus.dec_en && mon_iss < frame_n))
                    check("dec_en_timing", 32'(bus.dec_en), 32'(hs_prev));
                if (bus.dec_en) begin
                    exp_s = (mon_iss < frame_n) ? frame_sym[mon_iss] : 2'b00;
                    check("dec_sym", 32'(bus.dec_sym), 32'(exp_s));
                    mon_iss++;
                end
                if (prev_last) check("busy_after_last", 32'(bus.busy), 0);
                if (bus.out_valid) begin
                    if (out_cnt < frame_n) begin
                        check("out_bit", 32'(bus.out_bit), 32'(fbit(frame_sym[out_cnt])));
                        check("out_last", 32'(bus.out_last), 32'(out_cnt == frame_n - 1));
                    end
                    out_cnt++;
                end
                hs_prev   = bus.in_valid & bus.in_ready;
                prev_last = bus.out_valid & bus.out_last;
            end
        end
    end

    task automatic check_reset_vec(input string tag);
        logic [13:0] got;
        logic [13:0] exp;
        got = {bus.in_ready, bus.dec_clr, bus.dec_k, bus.dec_en, bus.dec_sym,
               bus.out_valid, bus.out_bit, bus.out_last, bus.busy, bus.err_cfg, bus.err_len};
        exp = {1'b0, 1'b0, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        check(tag, 32'(got), 32'(exp));
    endtask

    // Called at posedge+1; leaves the caller in the cycle after start.
    task automatic pulse_start(input logic [2:0] k);
        bus.cfg_k = k;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_sym(input logic [1:0] s, input bit last, input int gap_pct, input bit expect_acc);
        bit acc;
        int lim;
        for (int g = 0; g < 3; g++) begin
            if (int'($urandom_range(0, 99)) >= gap_pct) break;
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_sym   = s;
        bus.in_last  = last;
        acc = 1'b0;
        lim = expect_acc ? 40 : 6;
        for (int w = 0; w < lim && !acc; w++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("accept", 32'(acc), 32'(expect_acc));
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus.busy && w < 4000);
        check(tag, 32'(bus.busy), 0);
    endtask

    task automatic run_frame(input int n, input int gap_pct, input bit use_last,
                             input logic [2:0] k, input bit poke);
        int exp_n;
        exp_n = (n > MAX_FRAME) ? MAX_FRAME : n;
        for (int i = 0; i < n; i++) frame_sym[i] = 2'($urandom_range(0, 3));
        frame_n = exp_n;
        pulse_start(k);
        @(negedge clk);
        check("dec_clr", 32'(bus.dec_clr), 1);
        check("dec_k_latch", 32'(bus.dec_k), 32'(k));
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            send_sym(frame_sym[i], use_last && (i == n - 1), gap_pct, i < MAX_FRAME);
            if (poke && i == n - 1) begin
                repeat (3) @(posedge clk);
                #1;
                pulse_start(3'd6);
            end
        end
        wait_idle("frame_done");
        check("n_out", 32'(out_cnt), 32'(exp_n));
        check("n_issue", 32'(mon_iss), 32'(exp_n + TB_DEPTH - 1));
        check("err_len", 32'(bus.err_len), 32'(n > MAX_FRAME && !use_last));
        check("dec_k_hold", 32'(bus.dec_k), 32'(k));
        check("in_ready_idle", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic illegal_start(input logic [2:0] k);
        pulse_start(k);
        @(negedge clk);
        check("err_cfg_pulse", 32'(bus.err_cfg), 1);
        check("no_clr_on_bad_k", 32'(bus.dec_clr), 0);
        check("idle_on_bad_k", 32'(bus.busy), 0);
        @(negedge clk);
        check("err_cfg_one_cycle", 32'(bus.err_cfg), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_run();
        bit act;
        for (int i = 0; i < 30; i++) frame_sym[i] = 2'($urandom_range(0, 3));
        frame_n = 30;
        pulse_start(3'd5);
        @(negedge clk);
        check("dec_clr", 32'(bus.dec_clr), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_sym(frame_sym[i], 1'b0, 0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vec("reset_mid_run");
        @(posedge clk);
        #1;
        rst = 1'b0;
        act = 1'b0;
        repeat (20) begin
            @(negedge clk);
            act = act | bus.dec_en | bus.out_valid | bus.busy;
        end
        check("quiet_after_reset", 32'(act), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        bus.cfg_k    = 3'd3;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sym   = 2'b00;
        bus.in_last  = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_vec("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        illegal_start(3'd7);
        illegal_start(3'd2);
        check("dec_k_after_bad", 32'(bus.dec_k), 3);

        run_frame(20, 0, 1'b1, 3'd3, 1'b0);
        run_frame(30, 40, 1'b1, 3'd4, 1'b0);
        run_frame(1, 0, 1'b1, 3'd6, 1'b0);
        run_frame(12, 20, 1'b1, 3'd5, 1'b1);
        run_frame(1024, 0, 1'b0, 3'd3, 1'b0);
        for (int r = 0; r < 4; r++)
            run_frame(int'($urandom_range(1, 60)), int'($urandom_range(0, 50)), 1'b1,
                      3'(3 + $urandom_range(0, 3)), 1'b0);

        reset_mid_run();
        run_frame(5, 0, 1'b1, 3'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
